// File: rtl/spi_flash_pkg.sv
// Constants shared by the SPI flash master and slave: frame field widths, commands, FSM encoding.
package spi_flash_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h56;
  localparam logic [7:0] CMD_READ  = 8'hFF;
  localparam int CMD_W  = 8;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CMD    = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RDATA  = 3'd4;
  localparam logic [2:0] ST_IGNORE = 3'd5;

  function automatic logic cmd_valid(input logic [7:0] c);
    return (c == CMD_WRITE) || (c == CMD_READ);
  endfunction
endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchronizer plus a history flop; rise/fall pulse one clk, 2 clk after the pin edge.
// Free-running, no backpressure.
module spi_in_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= RST_VAL;
      s2   <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      s1   <= d;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;
endmodule

// File: rtl/spi_flash_slave.sv
// SPI mode-0 flash responder over a register-array word memory; 3 clk from pin edge to state update.
// No backpressure: the master paces everything through SCLK and CS.
module spi_flash_slave #(
  parameter int MEM_WORDS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic CS,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic wr_strobe,
  output logic cmd_err
);
  import spi_flash_pkg::*;

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic unused_edges;

  spi_in_sync #(.RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst(rst), .d(CS), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_in_sync #(.RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(SCLK), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst(rst), .d(MOSI), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_edges = ^{cs_rise, cs_fall, sclk_q, mosi_rise, mosi_fall};

  logic [2:0]        state;
  logic [5:0]        bit_cnt;
  logic [DATA_W-1:0] shreg, shnext, tx;
  logic [7:0]        cmd;
  logic [IDX_W-1:0]  index, nxt_idx, addr_idx;
  logic              rd_armed;
  logic [DATA_W-1:0] mem [MEM_WORDS];

  assign shnext   = {shreg[DATA_W-2:0], mosi_q};
  assign nxt_idx  = index + IDX_W'(1);
  assign addr_idx = shnext[IDX_W-1:0];
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      tx        <= '0;
      cmd       <= '0;
      index     <= '0;
      rd_armed  <= 1'b0;
      MISO      <= 1'b0;
      wr_strobe <= 1'b0;
      cmd_err   <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else begin
      wr_strobe <= 1'b0;
      cmd_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          MISO    <= 1'b0;
          bit_cnt <= '0;
          if (!cs_q) state <= ST_CMD;
        end
        ST_CMD: if (sclk_rise) begin
          shreg   <= shnext;
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'(CMD_W - 1)) begin
            cmd     <= shnext[7:0];
            bit_cnt <= '0;
            if (cmd_valid(shnext[7:0])) begin
              state <= ST_ADDR;
            end else begin
              cmd_err <= 1'b1;
              state   <= ST_IGNORE;
            end
          end
        end
        ST_ADDR: if (sclk_rise) begin
          shreg   <= shnext;
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'(ADDR_W - 1)) begin
            index    <= addr_idx;
            bit_cnt  <= '0;
            rd_armed <= 1'b0;
            if (cmd == CMD_READ) begin
              tx    <= mem[addr_idx];
              MISO  <= mem[addr_idx][DATA_W-1];
              state <= ST_RDATA;
            end else begin
              state <= ST_WDATA;
            end
          end
        end
        ST_WDATA: if (sclk_rise) begin
          shreg   <= shnext;
          bit_cnt <= bit_cnt + 6'd1;
          if (bit_cnt == 6'(DATA_W - 1)) begin
            mem[index] <= shnext;
            wr_strobe  <= 1'b1;
            index      <= nxt_idx;
            bit_cnt    <= '0;
          end
        end
        ST_RDATA: begin
          // Only falls that follow a data rise advance the shifter; the fall
          // closing the last address bit must keep bit 31 on MISO.
          if (sclk_rise) rd_armed <= 1'b1;
          if (sclk_fall && rd_armed) begin
            rd_armed <= 1'b0;
            if (bit_cnt == 6'(DATA_W - 1)) begin
              bit_cnt <= '0;
              index   <= nxt_idx;
              tx      <= mem[nxt_idx];
              MISO    <= mem[nxt_idx][DATA_W-1];
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
              tx      <= {tx[DATA_W-2:0], 1'b0};
              MISO    <= tx[DATA_W-2];
            end
          end
        end
        ST_IGNORE: MISO <= 1'b0;
        default: state <= ST_IDLE;
      endcase
      // Placed after the case so a word completing on this clk still commits.
      if (cs_q && state != ST_IDLE) begin
        state <= ST_IDLE;
        MISO  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_flash_slave.sv
// Directed plus randomized SPI frames against a word-array reference model of the flash memory.
module tb_spi_flash_slave;
  import spi_flash_pkg::*;

  localparam int MW = 16;

  logic clk = 1'b0;
  logic rst, cs, sclk, mosi;
  logic miso, busy, wr_strobe, cmd_err;

  spi_flash_slave #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .CS(cs), .SCLK(sclk), .MOSI(mosi),
    .MISO(miso), .busy(busy), .wr_strobe(wr_strobe), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  logic [31:0] mem_m [MW];
  logic [31:0] wq[$];
  logic [31:0] rq[$];

  always @(negedge clk) begin
    if (wr_strobe) wr_cnt++;
    if (cmd_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic xfer(input logic b, output logic m);
    mosi = b;
    wait_clk(5);
    m = miso;
    sclk = 1'b1;
    wait_clk(5);
    sclk = 1'b0;
  endtask

  function automatic int midx(input logic [23:0] a, input int k);
    return (int'(a[3:0]) + k) % MW;
  endfunction

  // Drives one complete frame; data words come from wq, sampled MISO words go to rq.
  task automatic frame(input logic [7:0] c, input logic [23:0] a, input int nbits);
    logic [31:0] w, r;
    logic m, hdr_miso, dat_miso;
    w = '0; r = '0; hdr_miso = 1'b0; dat_miso = 1'b0;
    rq.delete();
    cs = 1'b0;
    wait_clk(5);
    for (int i = 7; i >= 0; i--) begin xfer(c[i], m); hdr_miso |= m; end
    for (int i = 23; i >= 0; i--) begin xfer(a[i], m); hdr_miso |= m; end
    for (int i = 0; i < nbits; i++) begin
      if (i % 32 == 0) w = (wq.size() > 0) ? wq.pop_front() : 32'h0;
      xfer(w[31 - (i % 32)], m);
      dat_miso |= m;
      r = {r[30:0], m};
      if (i % 32 == 31) rq.push_back(r);
    end
    check("miso low in cmd/addr", {31'd0, hdr_miso}, 32'd0);
    if (c != CMD_READ) check("miso low outside read", {31'd0, dat_miso}, 32'd0);
    wait_clk(5);
    check("busy during frame", {31'd0, busy}, 32'd1);
    cs = 1'b1;
    wait_clk(2);
    check("busy 2 clk after cs rise", {31'd0, busy}, 32'd1);
    wait_clk(1);
    check("busy 3 clk after cs rise", {31'd0, busy}, 32'd0);
    wait_clk(5);
  endtask

  task automatic do_write(input logic [23:0] a, input int nbits);
    logic [31:0] words[$];
    int s0;
    words = wq;
    s0 = wr_cnt;
    frame(CMD_WRITE, a, nbits);
    for (int k = 0; k < nbits / 32; k++) mem_m[midx(a, k)] = words[k];
    check("wr_strobe pulses", wr_cnt - s0, nbits / 32);
  endtask

  task automatic do_read(input logic [23:0] a, input int nwords);
    frame(CMD_READ, a, nwords * 32);
    for (int k = 0; k < nwords; k++) check("read word", rq[k], mem_m[midx(a, k)]);
  endtask

  initial begin
    int s0, e0;
    logic m;
    logic [7:0] c8;
    logic [23:0] ra;
    int n;

    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 32'h0;
    wait_clk(3);
    check("reset miso", {31'd0, miso}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("reset cmd_err", {31'd0, cmd_err}, 32'd0);
    rst = 1'b0;
    wait_clk(3);

    do_read(24'h456FAB, 1);

    wq.push_back(32'h1234AADD);
    do_write(24'h258AFA, 32);
    do_read(24'h00000A, 1);

    wq.push_back(32'hAAAA5555);
    wq.push_back(32'h0F0F0F0F);
    do_write(24'h00000F, 64);
    do_read(24'h00000F, 2);

    s0 = wr_cnt; e0 = err_cnt;
    frame(8'h03, 24'h00000A, 24);
    check("bad cmd err pulses", err_cnt - e0, 32'd1);
    check("bad cmd no write", wr_cnt - s0, 32'd0);
    do_read(24'h00000A, 1);

    wq.push_back(32'h600DF00D);
    do_write(24'h000002, 32);
    wq.push_back(32'hDEADBEEF);
    do_write(24'h000002, 20);
    do_read(24'h000002, 1);

    // Reset in the middle of the address phase of a write
    s0 = wr_cnt;
    c8 = CMD_WRITE;
    cs = 1'b0;
    wait_clk(5);
    for (int i = 7; i >= 0; i--) xfer(c8[i], m);
    for (int i = 0; i < 10; i++) xfer(1'b1, m);
    rst = 1'b1;
    wait_clk(1);
    check("rst miso", {31'd0, miso}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst cmd_err", {31'd0, cmd_err}, 32'd0);
    rst = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 32'h0;
    wait_clk(5);
    cs = 1'b1;
    wait_clk(8);
    check("aborted frame no write", wr_cnt - s0, 32'd0);
    do_read(24'h00000A, 1);
    do_read(24'h00000F, 2);
    wq.push_back($urandom);
    do_write(24'h000001, 32);
    do_read(24'h000001, 1);

    for (int it = 0; it < 6; it++) begin
      ra = 24'($urandom);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) wq.push_back($urandom);
      do_write(ra, n * 32);
      ra = 24'($urandom);
      do_read(ra, $urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_flash_slave.md
# spi_flash_slave

Synthesizable SPI flash responder: the slave end of the command/address/data link driven by the SPI flash master. Mode 0, MSB first. Frame: 8-bit command, 24-bit address, then 32-bit data words. It accepts write (0x56) and read (0xFF) frames against a small internal word memory. It serves as the on-chip loopback target for master bring-up and as the DUT partner in system benches.

## Interface
- MEM_WORDS, 16: number of 32-bit words; power of two, 2..256.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- CS  in  1  chip select, active low, asynchronous to clk.
- SCLK  in  1  serial clock from master, asynchronous to clk.
- MOSI  in  1  serial data from master.
- MISO  out  1  serial data to master; 0 whenever not in a read data phase.
- busy  out  1  high while a frame is in progress (state ≠ IDLE).
- wr_strobe  out  1  one-clk pulse when a received 32-bit word is committed to memory.
- cmd_err  out  1  one-clk pulse when a completed command byte is neither 0x56 nor 0xFF.

## Operation
- CS, SCLK and MOSI pass through 2-flop synchronizers. SCLK rise/fall events come from the synchronized value and its previous value.
- Word index = Address[log2(MEM_WORDS)-1:0]. Upper address bits are ignored.
- States:
  - IDLE: wait for synced CS = 0, then → CMD with bit_cnt = 0.
  - CMD: shift MOSI in on each SCLK rise. After 8 bits, latch cmd. 0x56 or 0xFF → ADDR. Otherwise pulse cmd_err → IGNORE.
  - ADDR: shift 24 bits. On the 24th rise, latch word index. If cmd = 0xFF, load mem[index] into the tx shift register and drive its bit 31 on MISO. → WDATA or RDATA.
  - WDATA: shift 32 bits. On the 32nd rise, write mem[index], pulse wr_strobe, index = index+1 mod MEM_WORDS, restart the 32-bit count (burst write).
  - RDATA: on each SCLK fall, shift tx left and drive the new MSB. After the 32nd fall of a word, index++ (wrap), load the next word and drive its bit 31 (burst read).
  - IGNORE: hold MISO = 0 and ignore SCLK until CS rises.
- Synced CS = 1 in any state → IDLE next clk. A partial data word (<32 bits) is discarded; memory is unchanged.
- Reset: state IDLE, MISO 0, busy 0, wr_strobe 0, cmd_err 0, counters 0, all memory words 0x00000000, synchronizers cleared to CS = 1, SCLK = 0.

## Timing
- SCLK high and low phases must each be ≥ 3 clk periods. CS setup before the first SCLK rise and hold after the last SCLK fall must each be ≥ 3 clk periods. Behaviour outside these limits is undefined.
- Input-to-action latency: 3 clk from a pin edge to the state update (2 sync + 1 register).
- Read MSB appears on MISO ≤ 1 clk after the internal detection of the 24th address rise. This is valid before the master's next SCLK rise.
- wr_strobe asserts the clk after the 32nd data rise is detected, for exactly 1 clk.
- busy falls exactly 1 clk after synced CS = 1 is seen.
- A CS rise arriving in the same clk as the 32nd data rise: the write completes first (wr_strobe pulses), then → IDLE.
- rst has priority over every other event, including mid-frame. No write occurs for the aborted frame.

## Structure
- Shared package spi_flash_pkg: CMD_WRITE = 8'h56, CMD_READ = 8'hFF, CMD_W = 8, ADDR_W = 24, DATA_W = 32, and the state encoding. The master uses the same constants.
- Sub-module spi_in_sync: 2-flop synchronizer with rise/fall pulse outputs. Instantiated for SCLK, CS and MOSI; edge outputs unused where not needed.
- Memory is a register array, so it resets cleanly and is inferable as flops.

## Test plan
- Write 0x1234AADD at 0x258AFA (index 0xA): wr_strobe pulses once, then read at 0x00000A → MISO shifts 0x1234AADD MSB first.
- After reset, read at 0x456FAB (index 0xB) for 32 bits → MISO all 0, busy 1 during frame, 0 three clk after CS rise.
- Burst write 0xAAAA5555 then 0x0F0F0F0F starting at index 0xF: two wr_strobe pulses, then read 64 bits from 0xF → 0xAAAA5555, 0x0F0F0F0F (second word from index 0x0).
- Command 0x03 + 56 SCLKs: one cmd_err pulse, MISO constant 0, no wr_strobe, memory unchanged.
- Write to index 0x2 with CS raised after 20 data bits: no wr_strobe, later read of 0x2 → previous contents.
- Assert rst for 1 clk mid-ADDR phase: all outputs 0 next clk, memory cleared. A fresh write/read at 0x000001 then succeeds.
